// File: rtl/reg_file_rename.sv
// Architectural register file with rename tags.
// Each of ISSUE_W dispatch lanes reads two sources and allocates one destination per cycle.
// A single ROB port commits one result per cycle.
// Reads see same-bundle allocations from earlier lanes, and they also see a commit landing in the same cycle.
// A rollback clears every rename tag but keeps the committed values.
module reg_file_rename #(
  parameter int XLEN    = 32,
  parameter int REG_W   = 5,
  parameter int TAG_W   = 5,
  parameter int ISSUE_W = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [ISSUE_W*2*REG_W-1:0] rs_from_dsp,
  output logic [ISSUE_W*2*XLEN-1:0]  V_to_dsp,
  output logic [ISSUE_W*2*TAG_W-1:0] Q_to_dsp,
  input  logic [ISSUE_W-1:0]         ena_from_dsp,
  input  logic [ISSUE_W*REG_W-1:0]   rd_from_dsp,
  input  logic [ISSUE_W*TAG_W-1:0]   Q_from_dsp,
  input  logic                       commit_flag_from_rob,
  input  logic [REG_W-1:0]           rd_from_rob,
  input  logic [TAG_W-1:0]           Q_from_rob,
  input  logic [XLEN-1:0]            V_from_rob,
  input  logic                       rollback_from_rob
);

  localparam int REG_CNT = 1 << REG_W;

  logic [XLEN-1:0]  r_v [REG_CNT];
  logic [TAG_W-1:0] r_q [REG_CNT];

  // The commit clears the tag only if the register still waits on the committing entry.
  logic w_cmt_en;
  logic w_cmt_match;
  assign w_cmt_en    = commit_flag_from_rob && (rd_from_rob != '0);
  assign w_cmt_match = (r_q[rd_from_rob] == Q_from_rob);

  for (genvar gs = 0; gs < 2 * ISSUE_W; gs++) begin : g_slot
    localparam int LANE = gs / 2;

    logic [REG_W-1:0] w_idx;
    logic             w_fwd_hit;
    logic [TAG_W-1:0] w_fwd_tag;
    logic             w_byp_hit;
    logic [XLEN-1:0]  w_v;
    logic [TAG_W-1:0] w_q;

    assign w_idx     = rs_from_dsp[gs*REG_W +: REG_W];
    assign w_byp_hit = w_cmt_en && (rd_from_rob == w_idx) && w_cmt_match;

    // Forward the tag from the highest earlier lane in this bundle that renames the same register
    always_comb begin
      w_fwd_hit = 1'b0;
      w_fwd_tag = '0;
      for (int k = 0; k < LANE; k++) begin
        if (ena_from_dsp[k] && (rd_from_dsp[k*REG_W +: REG_W] == w_idx)) begin
          w_fwd_hit = 1'b1;
          w_fwd_tag = Q_from_dsp[k*TAG_W +: TAG_W];
        end
      end
    end

    // Select the source operand: x0, then intra-bundle rename, then commit bypass, then storage
    always_comb begin
      if (w_idx == '0) begin
        w_v = '0;
        w_q = '0;
      end else if (w_fwd_hit) begin
        w_v = '0;
        w_q = w_fwd_tag;
      end else if (w_byp_hit) begin
        w_v = V_from_rob;
        w_q = '0;
      end else begin
        w_v = r_v[w_idx];
        w_q = r_q[w_idx];
      end
    end

    assign V_to_dsp[gs*XLEN +: XLEN]   = w_v;
    assign Q_to_dsp[gs*TAG_W +: TAG_W] = w_q;
  end

  // Update the value array: reset clears it, a commit writes it, and a rollback never touches it
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REG_CNT; i++) begin
        r_v[i] <= '0;
      end
    end else if (w_cmt_en) begin
      r_v[rd_from_rob] <= V_from_rob;
    end
  end

  // Update the tag array: the commit clear comes first, and a later lane's allocation overrides it
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REG_CNT; i++) begin
        r_q[i] <= '0;
      end
    end else if (rollback_from_rob) begin
      for (int i = 0; i < REG_CNT; i++) begin
        r_q[i] <= '0;
      end
    end else begin
      if (w_cmt_en && w_cmt_match) begin
        r_q[rd_from_rob] <= '0;
      end
      for (int l = 0; l < ISSUE_W; l++) begin
        if (ena_from_dsp[l] && (rd_from_dsp[l*REG_W +: REG_W] != '0)) begin
          r_q[rd_from_dsp[l*REG_W +: REG_W]] <= Q_from_dsp[l*TAG_W +: TAG_W];
        end
      end
    end
  end

endmodule

// File: tb/tb_reg_file_rename.sv
// Self-checking bench for reg_file_rename: directed scenarios plus randomized traffic
// compared against an array-based model of the register/tag state.
module tb_reg_file_rename;

  localparam int XLEN    = 32;
  localparam int REG_W   = 5;
  localparam int TAG_W   = 5;
  localparam int ISSUE_W = 2;
  localparam int REG_CNT = 1 << REG_W;
  localparam int SLOTS   = 2 * ISSUE_W;

  logic                       clk;
  logic                       rst;
  logic [ISSUE_W*2*REG_W-1:0] rs_from_dsp;
  logic [ISSUE_W*2*XLEN-1:0]  V_to_dsp;
  logic [ISSUE_W*2*TAG_W-1:0] Q_to_dsp;
  logic [ISSUE_W-1:0]         ena_from_dsp;
  logic [ISSUE_W*REG_W-1:0]   rd_from_dsp;
  logic [ISSUE_W*TAG_W-1:0]   Q_from_dsp;
  logic                       commit_flag_from_rob;
  logic [REG_W-1:0]           rd_from_rob;
  logic [TAG_W-1:0]           Q_from_rob;
  logic [XLEN-1:0]            V_from_rob;
  logic                       rollback_from_rob;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state
  logic [XLEN-1:0]  mv [REG_CNT];
  logic [TAG_W-1:0] mq [REG_CNT];

  reg_file_rename #(.XLEN(XLEN), .REG_W(REG_W), .TAG_W(TAG_W), .ISSUE_W(ISSUE_W)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .rs_from_dsp         (rs_from_dsp),
    .V_to_dsp            (V_to_dsp),
    .Q_to_dsp            (Q_to_dsp),
    .ena_from_dsp        (ena_from_dsp),
    .rd_from_dsp         (rd_from_dsp),
    .Q_from_dsp          (Q_from_dsp),
    .commit_flag_from_rob(commit_flag_from_rob),
    .rd_from_rob         (rd_from_rob),
    .Q_from_rob          (Q_from_rob),
    .V_from_rob          (V_from_rob),
    .rollback_from_rob   (rollback_from_rob)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // An allocation must never carry tag 0
  always @(negedge clk) begin
    for (int k = 0; k < ISSUE_W; k++) begin
      if (!rst && ena_from_dsp[k] && Q_from_dsp[k*TAG_W +: TAG_W] == '0)
        $error("illegal tag 0 allocation on lane %0d", k);
    end
  end

  task automatic clear_inputs();
    rs_from_dsp          = '0;
    ena_from_dsp         = '0;
    rd_from_dsp          = '0;
    Q_from_dsp           = '0;
    commit_flag_from_rob = 1'b0;
    rd_from_rob          = '0;
    Q_from_rob           = '0;
    V_from_rob           = '0;
    rollback_from_rob    = 1'b0;
  endtask

  task automatic set_rs(input int slot, input int idx);
    rs_from_dsp[slot*REG_W +: REG_W] = REG_W'(idx);
  endtask

  task automatic set_alloc(input int lane, input int rd, input int tag);
    ena_from_dsp[lane]                = 1'b1;
    rd_from_dsp[lane*REG_W +: REG_W]  = REG_W'(rd);
    Q_from_dsp[lane*TAG_W +: TAG_W]   = TAG_W'(tag);
  endtask

  task automatic set_commit(input int rd, input int tag, input logic [XLEN-1:0] v);
    commit_flag_from_rob = 1'b1;
    rd_from_rob          = REG_W'(rd);
    Q_from_rob           = TAG_W'(tag);
    V_from_rob           = v;
  endtask

  function automatic logic [XLEN-1:0] dut_v(input int slot);
    return V_to_dsp[slot*XLEN +: XLEN];
  endfunction

  function automatic logic [TAG_W-1:0] dut_q(input int slot);
    return Q_to_dsp[slot*TAG_W +: TAG_W];
  endfunction

  // Apply one clock edge of architectural rules to the model
  task automatic model_update();
    int r;
    if (rst) begin
      for (int i = 0; i < REG_CNT; i++) begin mv[i] = '0; mq[i] = '0; end
      return;
    end
    r = int'(rd_from_rob);
    if (commit_flag_from_rob && r != 0) begin
      mv[r] = V_from_rob;
      if (mq[r] == Q_from_rob) mq[r] = '0;
    end
    if (rollback_from_rob) begin
      for (int i = 0; i < REG_CNT; i++) mq[i] = '0;
    end else begin
      for (int l = 0; l < ISSUE_W; l++) begin
        r = int'(rd_from_dsp[l*REG_W +: REG_W]);
        if (ena_from_dsp[l] && r != 0) mq[r] = Q_from_dsp[l*TAG_W +: TAG_W];
      end
    end
  endtask

  // Expected combinational read for one slot given current inputs and model state
  task automatic model_read(input int slot, output logic [XLEN-1:0] ev, output logic [TAG_W-1:0] eq);
    int idx;
    int lane;
    bit hit;
    idx  = int'(rs_from_dsp[slot*REG_W +: REG_W]);
    lane = slot / 2;
    hit  = 1'b0;
    ev   = '0;
    eq   = '0;
    if (idx == 0) return;
    for (int k = 0; k < lane; k++) begin
      if (ena_from_dsp[k] && int'(rd_from_dsp[k*REG_W +: REG_W]) == idx) begin
        hit = 1'b1;
        eq  = Q_from_dsp[k*TAG_W +: TAG_W];
      end
    end
    if (hit) return;
    if (commit_flag_from_rob && int'(rd_from_rob) == idx && mq[idx] == Q_from_rob) begin
      ev = V_from_rob;
      eq = '0;
    end else begin
      ev = mv[idx];
      eq = mq[idx];
    end
  endtask

  task automatic step();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    step();
    rst = 1'b0;
    set_rs(0, 5);
    set_rs(1, 31);
    #1;
    if (dut_v(0) !== 32'h0) begin n_fail++; $display("FAIL reset_x5_V got %h want %h", dut_v(0), 32'h0); end
    n_checks++;
    if (dut_q(0) !== 5'd0) begin n_fail++; $display("FAIL reset_x5_Q got %0d want 0", dut_q(0)); end
    n_checks++;
    if (dut_v(1) !== 32'h0) begin n_fail++; $display("FAIL reset_x31_V got %h want %h", dut_v(1), 32'h0); end
    n_checks++;
    if (dut_q(1) !== 5'd0) begin n_fail++; $display("FAIL reset_x31_Q got %0d want 0", dut_q(1)); end
    n_checks++;
    clear_inputs();
    set_commit(0, 0, 32'hDEAD);
    set_rs(0, 0);
    #1;
    if (dut_v(0) !== 32'h0 || dut_q(0) !== 5'd0) begin
      n_fail++; $display("FAIL x0_commit_same V=%h Q=%0d want 0/0", dut_v(0), dut_q(0));
    end
    n_checks++;
    step();
    clear_inputs();
    #1;
    if (dut_v(0) !== 32'h0 || dut_q(0) !== 5'd0) begin
      n_fail++; $display("FAIL x0_commit_next V=%h Q=%0d want 0/0", dut_v(0), dut_q(0));
    end
    n_checks++;
  endtask

  task automatic test_alloc_commit();
    clear_inputs();
    set_alloc(0, 3, 7);
    step();
    clear_inputs();
    set_rs(0, 3);
    #1;
    if (dut_q(0) !== 5'd7) begin n_fail++; $display("FAIL alloc_x3_Q got %0d want 7", dut_q(0)); end
    n_checks++;
    set_commit(3, 7, 32'h1234);
    #1;
    if (dut_v(0) !== 32'h1234 || dut_q(0) !== 5'd0) begin
      n_fail++; $display("FAIL bypass_x3 V=%h Q=%0d want 1234/0", dut_v(0), dut_q(0));
    end
    n_checks++;
    step();
    clear_inputs();
    set_rs(0, 3);
    #1;
    if (dut_v(0) !== 32'h1234 || dut_q(0) !== 5'd0) begin
      n_fail++; $display("FAIL stored_x3 V=%h Q=%0d want 1234/0", dut_v(0), dut_q(0));
    end
    n_checks++;
  endtask

  task automatic test_stale_commit();
    clear_inputs();
    set_alloc(0, 3, 7);
    step();
    clear_inputs();
    set_alloc(1, 3, 9);
    step();
    clear_inputs();
    set_commit(3, 7, 32'h55);
    set_rs(0, 3);
    #1;
    if (dut_v(0) !== 32'h1234 || dut_q(0) !== 5'd9) begin
      n_fail++; $display("FAIL stale_bypass_x3 V=%h Q=%0d want 1234/9", dut_v(0), dut_q(0));
    end
    n_checks++;
    step();
    clear_inputs();
    set_rs(0, 3);
    #1;
    if (dut_v(0) !== 32'h55 || dut_q(0) !== 5'd9) begin
      n_fail++; $display("FAIL stale_stored_x3 V=%h Q=%0d want 55/9", dut_v(0), dut_q(0));
    end
    n_checks++;
  endtask

  task automatic test_intra_bundle();
    clear_inputs();
    set_alloc(0, 4, 2);
    set_alloc(1, 4, 3);
    set_rs(0, 4);
    set_rs(2, 4);
    set_rs(3, 4);
    #1;
    if (dut_q(2) !== 5'd2 || dut_v(2) !== 32'h0) begin
      n_fail++; $display("FAIL fwd_lane1_rs1 V=%h Q=%0d want 0/2", dut_v(2), dut_q(2));
    end
    n_checks++;
    if (dut_q(3) !== 5'd2) begin n_fail++; $display("FAIL fwd_lane1_rs2_own Q got %0d want 2", dut_q(3)); end
    n_checks++;
    if (dut_q(0) !== 5'd0) begin n_fail++; $display("FAIL fwd_lane0_self Q got %0d want 0", dut_q(0)); end
    n_checks++;
    step();
    clear_inputs();
    set_rs(0, 4);
    #1;
    if (dut_q(0) !== 5'd3) begin n_fail++; $display("FAIL fwd_next_both Q got %0d want 3", dut_q(0)); end
    n_checks++;
    set_alloc(0, 4, 2);
    set_rs(0, 0);
    step();
    clear_inputs();
    set_rs(0, 4);
    #1;
    if (dut_q(0) !== 5'd2) begin n_fail++; $display("FAIL fwd_next_lane0 Q got %0d want 2", dut_q(0)); end
    n_checks++;
  endtask

  task automatic test_rollback();
    clear_inputs();
    set_alloc(0, 1, 4);
    set_alloc(1, 2, 5);
    step();
    clear_inputs();
    set_alloc(0, 6, 6);
    step();
    clear_inputs();
    set_rs(0, 1); set_rs(1, 2); set_rs(2, 6);
    #1;
    if (dut_q(0) !== 5'd4 || dut_q(1) !== 5'd5 || dut_q(2) !== 5'd6) begin
      n_fail++; $display("FAIL rb_pre_tags got %0d %0d %0d want 4 5 6", dut_q(0), dut_q(1), dut_q(2));
    end
    n_checks++;
    rollback_from_rob = 1'b1;
    set_commit(1, 4, 32'hAA);
    set_alloc(0, 7, 8);
    step();
    clear_inputs();
    set_rs(0, 1); set_rs(1, 2); set_rs(2, 6); set_rs(3, 7);
    #1;
    if (dut_v(0) !== 32'hAA || dut_q(0) !== 5'd0) begin
      n_fail++; $display("FAIL rb_x1 V=%h Q=%0d want AA/0", dut_v(0), dut_q(0));
    end
    n_checks++;
    if (dut_q(1) !== 5'd0 || dut_q(2) !== 5'd0 || dut_q(3) !== 5'd0) begin
      n_fail++; $display("FAIL rb_tags x2=%0d x6=%0d x7=%0d want 0", dut_q(1), dut_q(2), dut_q(3));
    end
    n_checks++;
    set_rs(0, 3);
    #1;
    if (dut_v(0) !== 32'h55 || dut_q(0) !== 5'd0) begin
      n_fail++; $display("FAIL rb_x3_retained V=%h Q=%0d want 55/0", dut_v(0), dut_q(0));
    end
    n_checks++;
  endtask

  task automatic test_reset_mid();
    clear_inputs();
    set_alloc(0, 9, 3);
    step();
    clear_inputs();
    rst = 1'b1;
    set_commit(9, 3, 32'h77);
    step();
    rst = 1'b0;
    clear_inputs();
    set_rs(0, 9); set_rs(1, 3); set_rs(2, 1);
    #1;
    if (dut_v(0) !== 32'h0 || dut_q(0) !== 5'd0) begin
      n_fail++; $display("FAIL rstmid_x9 V=%h Q=%0d want 0/0", dut_v(0), dut_q(0));
    end
    n_checks++;
    if (dut_v(1) !== 32'h0 || dut_v(2) !== 32'h0) begin
      n_fail++; $display("FAIL rstmid_values x3=%h x1=%h want 0", dut_v(1), dut_v(2));
    end
    n_checks++;
  endtask

  task automatic test_random();
    logic [XLEN-1:0]  ev;
    logic [TAG_W-1:0] eq;
    int r;
    for (int cyc = 0; cyc < 600; cyc++) begin
      clear_inputs();
      // Small register range so forwarding, bypass and collisions happen often
      for (int s = 0; s < SLOTS; s++) set_rs(s, $urandom_range(0, 7));
      for (int l = 0; l < ISSUE_W; l++)
        if ($urandom_range(0, 1) == 1) set_alloc(l, $urandom_range(0, 7), $urandom_range(1, 31));
      if ($urandom_range(0, 1) == 1) begin
        r = $urandom_range(0, 7);
        if ($urandom_range(0, 2) != 0) set_commit(r, int'(mq[r]), $urandom());
        else set_commit(r, $urandom_range(0, 31), $urandom());
      end
      rollback_from_rob = ($urandom_range(0, 19) == 0);
      rst = ($urandom_range(0, 79) == 0);
      #1;
      if (!rollback_from_rob) begin
        for (int s = 0; s < SLOTS; s++) begin
          model_read(s, ev, eq);
          if (dut_v(s) !== ev || dut_q(s) !== eq) begin
            n_fail++;
            $display("FAIL rand_cyc%0d_slot%0d V=%h Q=%0d want %h/%0d", cyc, s, dut_v(s), dut_q(s), ev, eq);
          end
          n_checks++;
        end
      end
      step();
    end
    rst = 1'b0;
    clear_inputs();
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    for (int i = 0; i < REG_CNT; i++) begin mv[i] = '0; mq[i] = '0; end
    #1;
    test_reset();
    test_alloc_commit();
    test_stale_commit();
    test_intra_bundle();
    test_rollback();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_file_rename.md
Name: reg_file_rename

Overview:
- Architectural register file with rename tags for the out-of-order core, serving dispatch and the ROB.
- Generalised successor to the single-lane register status table; a flat read/alloc/commit port set per lane.
- Supports ISSUE_W dispatch lanes, each with 2 source reads and 1 destination allocation.
- Adds intra-bundle rename forwarding, commit-to-read bypass, and a full rename-state flush on mispredict.

Parameters:
- XLEN, 32, data width.
- REG_W, 5, register index width; REG_CNT = 2**REG_W.
- TAG_W, 5, rename tag width; tag 0 reserved as "ready / no producer", ROB entries use 1..2**TAG_W-1.
- ISSUE_W, 2, dispatch lanes per cycle (1..4).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- rs_from_dsp  in  ISSUE_W*2*REG_W  source indices; lane l, source s at slot 2l+s.
- V_to_dsp  out  ISSUE_W*2*XLEN  source values, same slotting.
- Q_to_dsp  out  ISSUE_W*2*TAG_W  source tags, 0 = value valid.
- ena_from_dsp  in  ISSUE_W  per-lane allocation enable.
- rd_from_dsp  in  ISSUE_W*REG_W  per-lane destination.
- Q_from_dsp  in  ISSUE_W*TAG_W  per-lane allocated ROB tag (nonzero).
- commit_flag_from_rob  in  1  commit valid.
- rd_from_rob  in  REG_W  committed destination.
- Q_from_rob  in  TAG_W  committing entry tag.
- V_from_rob  in  XLEN  committed value.
- rollback_from_rob  in  1  mispredict flush.

Behaviour:
- Storage: V[REG_CNT] and Q[REG_CNT]. Register 0 reads V=0, Q=0 at all times; no write or alloc ever changes it.
- Reset (clk edge, rst=1): all V=0, all Q=0. Reads are combinational, so outputs follow immediately (all zero for any index).
- Read path, combinational, per slot (lane l, index r), in priority order:
  1. Intra-bundle: if some lane k<l has ena=1 and rd=r≠0, return Q=Q_from_dsp of the highest such k, V=0.
  2. Commit bypass: else if commit_flag=1, rd_from_rob=r≠0 and Q[r]==Q_from_rob, return V=V_from_rob, Q=0.
  3. Otherwise return stored V[r], Q[r].
- A lane's own rd never forwards to its own sources.
- Rollback overrides the read path: when rollback=1, read outputs are don't-care. Dispatch must not issue in that cycle.
- Write path, registered, per rising edge with rst=0, applied in this order:
  - Commit: if commit_flag=1 and rd≠0, V[rd] <= V_from_rob. If Q[rd]==Q_from_rob, Q[rd] <= 0; a stale tag leaves Q unchanged.
  - Allocation: for each lane with ena=1 and rd≠0, Q[rd] <= Q_from_dsp. V is unchanged, and the allocation Q overrides any commit clear of the same register. If several lanes target the same rd, the highest lane wins.
  - Rollback: if rollback=1, all Q <= 0 and allocations that cycle are discarded. A commit in the same cycle still writes V. V is never cleared.
- Latency: allocation and commit are visible through storage on the next cycle; the commit bypass and intra-bundle forwarding provide zero-cycle visibility.
- Reset mid-operation: rst dominates rollback, commit and alloc; all state returns to zero on that edge.
- Tag 0 presented on Q_from_dsp with ena=1 is illegal; it is flagged by a bench assertion and the hardware does not check it.

Test Plan:
- Reset then read x5, x31 -> V=0, Q=0. Read x0 after commit rd=0, V=0xDEAD -> still V=0, Q=0.
- Lane0 alloc x3 tag 7; next cycle read x3 -> Q=7. Commit rd=3, Q=7, V=0x1234 same cycle as read -> V=0x1234, Q=0 (bypass). Following cycle, storage gives the same.
- Lane0 alloc x3 tag 7, then lane1 alloc x3 tag 9. Commit rd=3, Q=7, V=0x55 -> x3 reads V=0x55, Q=9 (stale commit keeps newer tag).
- Same bundle: lane0 alloc x4 tag 2, lane1 rs1=x4 -> lane1 Q=2. Lane1 rs2=x4 with lane1 rd=x4 tag 3 -> lane1 sees 2, not 3. Next cycle x4 Q=2 if lane1 ena=0, else Q=3.
- Tags held on x1 (4), x2 (5), x6 (6). Rollback together with commit rd=1, Q=4, V=0xAA and lane0 alloc x7 tag 8 -> next cycle all Q=0, x1 V=0xAA, x7 Q=0, other V retained.
- Alloc x9 tag 3, then rst=1 the same cycle as commit rd=9, V=0x77 -> all V=0, Q=0; x9 V=0.
